// File: rtl/fifo_sram_ctrl_if.sv
// fifo_sram_ctrl_if: valid/ready push and pop handshakes of the SRAM-backed FIFO.
interface fifo_sram_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/fifo_sram_ctrl.sv
// fifo_sram_ctrl: FWFT FIFO over an external SRAM (1-cycle read) plus a 2-entry output buffer.
// Define FIFO_SRAM_CTRL_WATERMARK_EN to build the registered almost_full/almost_empty flags.
module fifo_sram_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  fifo_sram_ctrl_if.slave       bus,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [WIDTH-1:0]      ram_wdata_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [WIDTH-1:0]      ram_rdata_b
);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   ram_used, ram_used_n;
  logic                  fetch_pend, push, pop, fetch;
  logic [1:0]            buf_cnt, buf_cnt_n, cnt_ap;
  logic [WIDTH-1:0]      buf0, buf1, buf0_n, buf1_n;
  logic [ADDR_WIDTH+1:0] level_n;
  assign bus.in_ready  = (ram_used != (ADDR_WIDTH+1)'(DEPTH)) && !flush;
  assign bus.out_valid = buf_cnt != 2'd0;
  assign bus.out_data  = buf0;
  assign ram_addr_a    = wr_ptr;
  assign ram_wdata_a   = bus.in_data;
  assign ram_we_a      = push;
  assign ram_addr_b    = rd_ptr;
  // A fetch is only issued when its word is guaranteed a buffer slot on return.
  always_comb begin
    push       = bus.in_valid && bus.in_ready;
    pop        = (buf_cnt != 2'd0) && bus.out_ready;
    cnt_ap     = buf_cnt - 2'(pop);
    fetch      = (ram_used != '0) && ((2'd2 - cnt_ap) > 2'(fetch_pend));
    ram_used_n = ram_used + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(fetch);
    buf0_n     = (fetch_pend && cnt_ap == 2'd0) ? ram_rdata_b : pop ? buf1 : buf0;
    buf1_n     = (fetch_pend && cnt_ap == 2'd1) ? ram_rdata_b : buf1;
    buf_cnt_n  = cnt_ap + 2'(fetch_pend);
    level_n    = flush ? '0 : (ADDR_WIDTH+2)'(ram_used_n) + (ADDR_WIDTH+2)'(fetch) + (ADDR_WIDTH+2)'(buf_cnt_n);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_used   <= '0;
      fetch_pend <= 1'b0;
      buf0       <= '0;
      buf1       <= '0;
      buf_cnt    <= 2'd0;
      level      <= '0;
    end else begin
      wr_ptr     <= wr_ptr + ADDR_WIDTH'(push);
      rd_ptr     <= rd_ptr + ADDR_WIDTH'(fetch);
      ram_used   <= ram_used_n;
      fetch_pend <= fetch;
      buf0       <= buf0_n;
      buf1       <= buf1_n;
      buf_cnt    <= buf_cnt_n;
      level      <= level_n;
    end
  end
`ifdef FIFO_SRAM_CTRL_WATERMARK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= level_n >= (ADDR_WIDTH+2)'(AF_LEVEL);
      almost_empty <= level_n <= (ADDR_WIDTH+2)'(AE_LEVEL);
    end
  end
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_sram_ctrl.sv
// tb_fifo_sram_ctrl: directed self-checking bench for fifo_sram_ctrl with a behavioural SRAM.
module tb_fifo_sram_ctrl;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 3;
`ifdef FIFO_SRAM_CTRL_WATERMARK_EN
  localparam bit WM = 1'b1;
`else
  localparam bit WM = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [AW+1:0] level;
  logic          almost_full, almost_empty;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [W-1:0]  ram_wdata_a, ram_rdata_b;
  logic          ram_we_a;
  logic [W-1:0]  mem [D];
  int            n_tests = 0;
  int            n_fail = 0;
  logic [W-1:0]  exp_q[$];
  fifo_sram_ctrl_if #(.WIDTH(W)) bus ();
  fifo_sram_ctrl #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .level(level),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .ram_addr_a(ram_addr_a), .ram_wdata_a(ram_wdata_a), .ram_we_a(ram_we_a),
    .ram_addr_b(ram_addr_b), .ram_rdata_b(ram_rdata_b)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
    ram_rdata_b <= mem[ram_addr_b];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic drain(input int maxc);
    bus.out_ready = 1'b1;
    for (int i = 0; i < maxc && exp_q.size() > 0; i++) begin
      if (bus.out_valid) chk("drain_data", bus.out_data, exp_q.pop_front());
      @(negedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
    bus.out_ready = 1'b0;
  endtask
  task automatic push_n(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + W'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int first_pop, last_pop, pops;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ae", almost_empty, WM);
    rst_n = 1'b1;
    @(negedge clk);
    // first-word latency
    bus.in_valid = 1'b1; bus.in_data = 16'h0001;
    @(negedge clk); chk("lat_ov_e0", bus.out_valid, 0); bus.in_data = 16'h0002;
    @(negedge clk); chk("lat_ov_e1", bus.out_valid, 0); bus.in_data = 16'h0003;
    @(negedge clk); bus.in_valid = 1'b0;
    chk("lat_ov_e2", bus.out_valid, 1);
    chk("lat_data", bus.out_data, 16'h0001);
    chk("lat_level", level, 3);
    exp_q = '{16'h0001, 16'h0002, 16'h0003};
    drain(20);
    chk("lat_level_end", level, 0);
    // fill to capacity DEPTH+2
    push_n(16'h0100, 10);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_level", level, 10);
    bus.in_valid = 1'b1; bus.in_data = 16'h01FF;
    #1 chk("full_we", ram_we_a, 0);
    @(negedge clk); bus.in_valid = 1'b0;
    chk("full_level_hold", level, 10);
    for (int i = 0; i < 10; i++) exp_q.push_back(16'h0100 + 16'(i));
    drain(40);
    chk("full_level_end", level, 0);
    chk("full_in_ready_end", bus.in_ready, 1);
    // streaming one word per cycle
    first_pop = -1; last_pop = -1; pops = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 46; i++) begin
      bus.in_valid = i < 40;
      bus.in_data  = 16'(i);
      if (bus.out_valid) begin
        chk("stream_data", bus.out_data, pops);
        if (first_pop < 0) first_pop = i;
        last_pop = i;
        pops++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("stream_pops", pops, 40);
    chk("stream_first", first_pop, 3);
    chk("stream_last", last_pop, 42);
    chk("stream_level", level, 0);
    // flush with a concurrent push
    push_n(16'h0300, 6);
    chk("flush_pre_level", level, 6);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
    #1 chk("flush_in_ready", bus.in_ready, 0);
    chk("flush_we", ram_we_a, 0);
    @(negedge clk); flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_ov", bus.out_valid, 0);
    @(negedge clk);
    chk("flush_ov_late", bus.out_valid, 0);
    chk("flush_level_late", level, 0);
    push_n(16'hBEEF, 1);
    exp_q = '{16'hBEEF};
    drain(20);
    // watermarks: fill to 6 then pop one at a time down to 2
    for (int k = 1; k <= 6; k++) begin
      push_n(16'h0200 + 16'(k), 1);
      chk("wm_fill_level", level, k);
      chk("wm_fill_af", almost_full, WM && k >= 6);
      chk("wm_fill_ae", almost_empty, WM && k <= 2);
    end
    for (int k = 5; k >= 2; k--) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("wm_drain_level", level, k);
      chk("wm_drain_af", almost_full, WM && k >= 6);
      chk("wm_drain_ae", almost_empty, WM && k <= 2);
    end
    exp_q = '{16'h0205, 16'h0206};
    drain(20);
    // asynchronous reset mid-stream
    push_n(16'h0400, 5);
    chk("arst_pre_level", level, 5);
    #2 rst_n = 1'b0;
    #1 chk("arst_ov", bus.out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    push_n(16'h0A5A, 2);
    exp_q = '{16'h0A5A, 16'h0A5B};
    drain(20);
    chk("arst_level_end", level, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
